// File: rtl/cpu_program_loader.sv
// Stream-driven program loader: decodes headers from a 32-bit valid/ready stream, fills
// instruction/data memory through the cpu external ports, then runs the core for a bounded time.
module cpu_program_loader #(
  parameter int unsigned RUN_CYCLES = 1000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  input  logic             halt_req,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  output logic             busy,
  output logic             done,
  output logic             hdr_err,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadI,
    StLoadDLo,
    StLoadDHi,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] OpImem = 2'b00;
  localparam logic [1:0] OpDmem = 2'b01;
  localparam logic [1:0] OpRun  = 2'b10;

  // Last cycle_count value of a budgeted run; unused when RUN_CYCLES is 0.
  localparam int unsigned     RunLastInt = (RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1;
  localparam logic [CNT_W-1:0] RunLast   = CNT_W'(RunLastInt);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  state_e           state_q, state_d;
  logic [13:0]      ptr_q, ptr_d;
  logic [15:0]      remain_q, remain_d;
  logic [31:0]      lo_q, lo_d;
  logic             wen_imem_q, wen_imem_d;
  logic [13:0]      widx_imem_q, widx_imem_d;
  logic [31:0]      wdata_imem_q, wdata_imem_d;
  logic             wen_dmem_q, wen_dmem_d;
  logic [13:0]      widx_dmem_q, widx_dmem_d;
  logic [63:0]      wdata_dmem_q, wdata_dmem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hdr_err_q, hdr_err_d;
  logic             accept;
  logic             run_exit;

  assign s_ready = (state_q != StRun) && (state_q != StDone);
  assign accept  = s_valid & s_ready;

  assign run_exit = halt_req || ((RUN_CYCLES != 0) && (cnt_q == RunLast));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remain_d     = remain_q;
    lo_d         = lo_q;
    wen_imem_d   = 1'b0;
    widx_imem_d  = widx_imem_q;
    wdata_imem_d = wdata_imem_q;
    wen_dmem_d   = 1'b0;
    widx_dmem_d  = widx_dmem_q;
    wdata_dmem_d = wdata_dmem_q;
    cnt_d        = cnt_q;
    hdr_err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if ((s_data[31:30] == OpImem) || (s_data[31:30] == OpDmem)) begin
            // Zero-length loads are accepted and silently discarded.
            if (s_data[15:0] != 16'd0) begin
              ptr_d    = s_data[29:16];
              remain_d = s_data[15:0];
              state_d  = (s_data[31:30] == OpImem) ? StLoadI : StLoadDLo;
            end
          end else if (s_data[31:30] == OpRun) begin
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            hdr_err_d = 1'b1;
          end
        end
      end

      StLoadI: begin
        if (accept) begin
          wen_imem_d   = 1'b1;
          widx_imem_d  = ptr_q;
          wdata_imem_d = s_data;
          ptr_d        = ptr_q + 14'd1;
          remain_d     = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = StIdle;
          end
        end
      end

      StLoadDLo: begin
        if (accept) begin
          lo_d    = s_data;
          state_d = StLoadDHi;
        end
      end

      StLoadDHi: begin
        if (accept) begin
          wen_dmem_d   = 1'b1;
          widx_dmem_d  = ptr_q;
          wdata_dmem_d = {s_data, lo_q};
          ptr_d        = ptr_q + 14'd1;
          remain_d     = remain_q - 16'd1;
          state_d      = (remain_q == 16'd1) ? StIdle : StLoadDLo;
        end
      end

      StRun: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (run_exit) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      remain_q     <= '0;
      lo_q         <= '0;
      wen_imem_q   <= 1'b0;
      widx_imem_q  <= '0;
      wdata_imem_q <= '0;
      wen_dmem_q   <= 1'b0;
      widx_dmem_q  <= '0;
      wdata_dmem_q <= '0;
      cnt_q        <= '0;
      hdr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remain_q     <= remain_d;
      lo_q         <= lo_d;
      wen_imem_q   <= wen_imem_d;
      widx_imem_q  <= widx_imem_d;
      wdata_imem_q <= wdata_imem_d;
      wen_dmem_q   <= wen_dmem_d;
      widx_dmem_q  <= widx_dmem_d;
      wdata_dmem_q <= wdata_dmem_d;
      cnt_q        <= cnt_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  assign cpu_enable  = (state_q == StRun);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign hdr_err     = hdr_err_q;
  assign cycle_count = cnt_q;

  // Word index to byte address: imem words are 4 bytes, dmem words are 8 bytes.
  assign addr_ext    = {48'd0, widx_imem_q, 2'b00};
  assign wen_ext     = wen_imem_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_imem_q;
  assign addr_ext_2  = {47'd0, widx_dmem_q, 3'b000};
  assign wen_ext_2   = wen_dmem_q;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = wdata_dmem_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboarded bench for cpu_program_loader: expected memory writes are queued when stimulus
// is driven and checked by a monitor as the write ports fire.
module tb_cpu_program_loader;

  localparam int unsigned RunCycles = 10;
  localparam int unsigned CntW      = 32;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  logic            clk;
  logic            arst_n;
  logic            s_valid;
  logic [31:0]     s_data;
  logic            s_ready;
  logic            halt_req;
  logic            cpu_enable;
  logic [63:0]     addr_ext;
  logic            wen_ext;
  logic            ren_ext;
  logic [31:0]     wdata_ext;
  logic [63:0]     addr_ext_2;
  logic            wen_ext_2;
  logic            ren_ext_2;
  logic [63:0]     wdata_ext_2;
  logic            busy;
  logic            done;
  logic            hdr_err;
  logic [CntW-1:0] cycle_count;

  int  vectors;
  int  miscompares;
  wr_t imem_q[$];
  wr_t dmem_q[$];

  cpu_program_loader #(
    .RUN_CYCLES(RunCycles),
    .CNT_W     (CntW)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .halt_req   (halt_req),
    .cpu_enable (cpu_enable),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .addr_ext_2 (addr_ext_2),
    .wen_ext_2  (wen_ext_2),
    .ren_ext_2  (ren_ext_2),
    .wdata_ext_2(wdata_ext_2),
    .busy       (busy),
    .done       (done),
    .hdr_err    (hdr_err),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (arst_n) begin
      if (wen_ext && wen_ext_2) begin
        vectors++;
        miscompares++;
        $display("FAIL both_wen: wen_ext=%b wen_ext_2=%b required not both", wen_ext, wen_ext_2);
      end
      if (wen_ext) begin
        vectors++;
        if (imem_q.size() == 0) begin
          miscompares++;
          $display("FAIL imem_unexpected: addr=%h data=%h required no write", addr_ext, wdata_ext);
        end else begin
          e = imem_q.pop_front();
          if (addr_ext !== e.addr || wdata_ext !== e.data[31:0]) begin
            miscompares++;
            $display("FAIL imem_write: got addr=%h data=%h required addr=%h data=%h",
                     addr_ext, wdata_ext, e.addr, e.data[31:0]);
          end
        end
      end
      if (wen_ext_2) begin
        vectors++;
        if (dmem_q.size() == 0) begin
          miscompares++;
          $display("FAIL dmem_unexpected: addr=%h data=%h required no write",
                   addr_ext_2, wdata_ext_2);
        end else begin
          e = dmem_q.pop_front();
          if (addr_ext_2 !== e.addr || wdata_ext_2 !== e.data) begin
            miscompares++;
            $display("FAIL dmem_write: got addr=%h data=%h required addr=%h data=%h",
                     addr_ext_2, wdata_ext_2, e.addr, e.data);
          end
        end
      end
    end
  end

  // Presents a word and returns on the negedge after it is accepted, leaving s_valid high.
  task automatic send(input logic [31:0] w);
    bit ok;
    ok      = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word=%h not accepted, s_ready=%b required 1", w, s_ready);
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic push_imem(input int s, input int i, input logic [31:0] d);
    wr_t e;
    e.addr = 64'(((s + i) % 16384) * 4);
    e.data = {32'd0, d};
    imem_q.push_back(e);
  endtask

  task automatic push_dmem(input int s, input int i, input logic [63:0] d);
    wr_t e;
    e.addr = 64'(((s + i) % 16384) * 8);
    e.data = d;
    dmem_q.push_back(e);
  endtask

  task automatic test_reset();
    arst_n   = 1'b0;
    halt_req = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    vectors++;
    if ({s_ready, busy, done, hdr_err, cpu_enable, wen_ext, wen_ext_2, ren_ext, ren_ext_2}
        !== 9'b1_0000_0000) begin
      miscompares++;
      $display("FAIL reset_flags: s_ready=%b busy=%b done=%b hdr_err=%b en=%b required s_ready=1 rest 0",
               s_ready, busy, done, hdr_err, cpu_enable);
    end
    vectors++;
    if (cycle_count !== '0 || addr_ext !== '0 || addr_ext_2 !== '0 || wdata_ext_2 !== '0) begin
      miscompares++;
      $display("FAIL reset_values: cycle_count=%0d addr=%h addr2=%h required all 0",
               cycle_count, addr_ext, addr_ext_2);
    end
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_imem_load();
    logic [31:0] words [3];
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    send(32'h0002_0003);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL imem_busy: busy=%b required 1", busy);
    end
    for (int i = 0; i < 3; i++) begin
      push_imem(2, i, words[i]);
      send(words[i]);
      // Back-to-back acceptance must yield a write in every following cycle.
      vectors++;
      if (wen_ext !== 1'b1) begin
        miscompares++;
        $display("FAIL imem_b2b_wen: word %0d wen_ext=%b required 1", i, wen_ext);
      end
    end
    idle();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || wen_ext !== 1'b0) begin
      miscompares++;
      $display("FAIL imem_end: busy=%b wen_ext=%b required 0 0", busy, wen_ext);
    end
  endtask

  task automatic test_dmem_load();
    send(32'h4001_0001);
    send(32'hDEAD_BEEF);
    vectors++;
    if (wen_ext_2 !== 1'b0) begin
      miscompares++;
      $display("FAIL dmem_lo_nowrite: wen_ext_2=%b required 0", wen_ext_2);
    end
    push_dmem(1, 0, 64'h0123_4567_DEAD_BEEF);
    send(32'h0123_4567);
    vectors++;
    if (wen_ext_2 !== 1'b1) begin
      miscompares++;
      $display("FAIL dmem_hi_write: wen_ext_2=%b required 1", wen_ext_2);
    end
    // Two entries back-to-back at S=0x10.
    send(32'h4010_0002);
    for (int i = 0; i < 2; i++) begin
      send(32'hA000_0000 + 32'(i));
      push_dmem(16, i, {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)});
      send(32'hB000_0000 + 32'(i));
    end
    idle();
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dmem_end_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_run_budget();
    int en;
    send(32'h8000_0000);
    idle();
    vectors++;
    if (cpu_enable !== 1'b1 || cycle_count !== '0) begin
      miscompares++;
      $display("FAIL run_start: cpu_enable=%b cycle_count=%0d required 1 0", cpu_enable, cycle_count);
    end
    en = 0;
    for (int i = 0; i < 50 && cpu_enable; i++) begin
      en++;
      vectors++;
      if (s_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL run_s_ready: cycle %0d s_ready=%b required 0", en, s_ready);
      end
      @(negedge clk);
    end
    vectors++;
    if (en != 10) begin
      miscompares++;
      $display("FAIL run_enable_cycles: got %0d required 10", en);
    end
    vectors++;
    if (done !== 1'b1 || cycle_count !== 32'd10) begin
      miscompares++;
      $display("FAIL run_done: done=%b cycle_count=%0d required 1 10", done, cycle_count);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || cycle_count !== 32'd10) begin
      miscompares++;
      $display("FAIL run_after: done=%b busy=%b cycle_count=%0d required 0 0 10",
               done, busy, cycle_count);
    end
  endtask

  task automatic test_halt();
    send(32'h8000_0000);
    idle();
    vectors++;
    if (cycle_count !== '0) begin
      miscompares++;
      $display("FAIL halt_clear: cycle_count=%0d required 0", cycle_count);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (cpu_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_4th_cycle: cpu_enable=%b required 1", cpu_enable);
    end
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    vectors++;
    if (cpu_enable !== 1'b0 || done !== 1'b1 || cycle_count !== 32'd4) begin
      miscompares++;
      $display("FAIL halt_exit: cpu_enable=%b done=%b cycle_count=%0d required 0 1 4",
               cpu_enable, done, cycle_count);
    end
    @(negedge clk);
    halt_req = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cpu_enable !== 1'b0 || done !== 1'b0 || cycle_count !== 32'd4) begin
      miscompares++;
      $display("FAIL halt_idle: busy=%b en=%b done=%b cycle_count=%0d required 0 0 0 4",
               busy, cpu_enable, done, cycle_count);
    end
    halt_req = 1'b0;
  endtask

  task automatic test_edge_headers();
    send(32'hC000_0000);
    idle();
    vectors++;
    if (hdr_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hdr_err_pulse: hdr_err=%b busy=%b required 1 0", hdr_err, busy);
    end
    @(negedge clk);
    vectors++;
    if (hdr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL hdr_err_width: hdr_err=%b required 0", hdr_err);
    end
    send(32'h0000_0000);
    idle();
    vectors++;
    if (busy !== 1'b0 || hdr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len: busy=%b hdr_err=%b required 0 0", busy, hdr_err);
    end
    send(32'h3FFF_0002);
    push_imem(16383, 0, 32'hCAFE_0000);
    send(32'hCAFE_0000);
    push_imem(16383, 1, 32'hCAFE_0001);
    send(32'hCAFE_0001);
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    send(32'h4001_0001);
    send(32'h5555_5555);
    idle();
    vectors++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_load_state: busy=%b s_ready=%b required 1 1", busy, s_ready);
    end
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || cycle_count !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b s_ready=%b cycle_count=%0d required 0 1 0",
               busy, s_ready, cycle_count);
    end
    // Fresh imem load with producer stalls between words.
    send(32'h0005_0003);
    idle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      push_imem(5, k, 32'h7000_0000 + 32'(k));
      send(32'h7000_0000 + 32'(k));
      idle();
      repeat (k + 1) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_drain();
    repeat (3) @(negedge clk);
    vectors++;
    if (imem_q.size() != 0 || dmem_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: imem pending=%0d dmem pending=%0d required 0 0",
               imem_q.size(), dmem_q.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    s_valid     = 1'b0;
    s_data      = '0;
    halt_req    = 1'b0;
    arst_n      = 1'b0;
    @(negedge clk);
    test_reset();
    test_imem_load();
    test_dmem_load();
    test_run_budget();
    test_halt();
    test_edge_headers();
    test_reset_mid_load();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Sits directly upstream of the cpu top and drives its external memory ports and its enable input.
- Accepts a 32-bit valid/ready word stream from the test or host side.
- Decodes load headers, writes payload words into instruction memory (32-bit) or data memory (64-bit, assembled from two stream words), then runs the core for a bounded number of cycles and reports completion.

Parameters:
RUN_CYCLES, 1000, run budget in clock cycles; 0 = unlimited (stop only on halt_req)
CNT_W, 32, width of cycle_count

Ports:
clk  input  1  clock
arst_n  input  1  reset, synchronous, active-low
s_valid  input  1  stream word valid
s_data  input  32  stream word
s_ready  output  1  loader accepts s_data this cycle
halt_req  input  1  stop core while in RUN
cpu_enable  output  1  to cpu enable
addr_ext  output  64  imem byte address
wen_ext  output  1  imem write enable
ren_ext  output  1  imem read enable, tied 0
wdata_ext  output  32  imem write word
addr_ext_2  output  64  dmem byte address
wen_ext_2  output  1  dmem write enable
ren_ext_2  output  1  dmem read enable, tied 0
wdata_ext_2  output  64  dmem write word
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at end of RUN
hdr_err  output  1  one-cycle pulse on reserved header
cycle_count  output  CNT_W  cycles spent in the last or current RUN

Behaviour:
- Reset: clk and arst_n as named; reset is synchronous and active-low, sampled on the rising clk edge. State=IDLE. All outputs 0 except s_ready=1. Counters cleared.
- Handshake: a word transfers on a clk edge with s_valid & s_ready.
- s_ready=1 in IDLE, LOAD_I, LOAD_D_LO and LOAD_D_HI. s_ready=0 in RUN and DONE.
- Header decode (IDLE only):
  - [31:30]=00 imem load; 01 dmem load; 10 run; 11 reserved.
  - [29:16]=start word index S (14 bits); [15:0]=word count N.
- Load header, N=0: stays IDLE, no writes.
- Load header, N>0: loads S and N; goes to LOAD_I (00) or LOAD_D_LO (01).
- Reserved header: pulses hdr_err next cycle; stays IDLE; word is dropped.
- LOAD_I: the i-th accepted word (i from 0) is written one cycle after acceptance.
  - wen_ext=1 for exactly 1 cycle.
  - addr_ext = ((S+i) mod 2^14) * 4, zero-extended to 64 bits.
  - wdata_ext = word.
  - After word N-1 is accepted, return to IDLE.
- LOAD_D_LO / LOAD_D_HI: the first word is held as bits [31:0]; the second word supplies bits [63:32].
  - On acceptance of the second word, the next cycle has wen_ext_2=1 for 1 cycle.
  - addr_ext_2 = ((S+i) mod 2^14) * 8.
  - wdata_ext_2 = {hi,lo}.
  - N 64-bit words consume 2N stream words. After the hi word of entry N-1, return to IDLE.
- Write ports: wen_ext and wen_ext_2 are never high simultaneously. Addresses and data hold their last value when not writing.
- Back-to-back words with s_valid held high give one write per cycle (LOAD_I) or one write per 2 cycles (dmem).
- Run header: next cycle enters RUN, cpu_enable=1, cycle_count cleared to 0.
  - The final load write (issued one cycle after the last acceptance) completes before or in the same cycle as cpu_enable rising.
  - In RUN, cycle_count increments each cycle that cpu_enable=1 and saturates at all-ones.
- RUN exit: when halt_req=1, or when RUN_CYCLES!=0 and cycle_count==RUN_CYCLES-1, the loader enters DONE next cycle.
  - On exit, cpu_enable drops and cycle_count holds the final value.
  - If both exit conditions occur in the same cycle, the result is identical to either one alone.
- DONE: done=1 for 1 cycle, then IDLE. cycle_count keeps its value until the next run header.
- halt_req outside RUN is ignored.
- Reset mid-operation: immediate return to reset values on the sampling edge. Memory contents already written are not undone. A half-assembled dmem word is discarded.
- s_valid while s_ready=0: word is not consumed; the producer must hold it.

Test Plan:
- Imem load: stream 0x00020003, then 0x11111111, 0x22222222, 0x33333333 -> wen_ext pulses with addr 8/12/16 and data 0x11111111/0x22222222/0x33333333; busy is 0 afterwards.
- Dmem load: stream 0x40010001, then 0xDEADBEEF, 0x01234567 -> single wen_ext_2 pulse, addr_ext_2=8, wdata_ext_2=0x01234567DEADBEEF.
- Run with RUN_CYCLES=10, header 0x80000000 -> cpu_enable high exactly 10 cycles, done pulse once, cycle_count=10, s_ready=0 throughout RUN.
- halt_req asserted on the 4th RUN cycle -> cpu_enable drops next cycle, cycle_count=4, done pulses; halt_req asserted in IDLE has no effect.
- Edge headers: 0xC0000000 -> hdr_err pulse, no writes; 0x00000000 -> no writes, stays IDLE; imem header with S=0x3FFF, N=2 -> addresses 0xFFFC then 0x0.
- Reset asserted after the lo word of a dmem load -> no wen_ext_2; after reset, a fresh imem load works normally; s_valid stalls mid-load insert gaps without lost or duplicated writes.
